// File: rtl/match_pkg.sv
// Shared types for the foosball match sequencer: state codes, winner codes
// and the winner decision.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    KICKOFF     = 3'd1,
    PLAY        = 3'd2,
    PAUSED      = 3'd3,
    GOAL_FREEZE = 3'd4,
    HALFTIME    = 3'd5,
    GAME_OVER   = 3'd6
  } match_state_t;

  typedef logic [1:0] winner_t;

  localparam winner_t WINNER_NONE = 2'b00;
  localparam winner_t WINNER_P1   = 2'b01;
  localparam winner_t WINNER_P2   = 2'b10;
  localparam winner_t WINNER_DRAW = 2'b11;

  function automatic winner_t decide_winner(input logic [3:0] s1, input logic [3:0] s2);
    if (s1 > s2) return WINNER_P1;
    if (s2 > s1) return WINNER_P2;
    return WINNER_DRAW;
  endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable 4-bit seconds down-counter; done flags the tick that takes it
// from 1 to 0. A load in the same cycle as a tick takes priority.
module sec_countdown (
  input  logic       clk,
  input  logic       resetN,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       tick,
  output logic [3:0] cnt,
  output logic       done
);

  assign done = tick & (cnt == 4'd1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      cnt <= 4'd0;
    else if (load)
      cnt <= load_val;
    else if (tick && cnt != 4'd0)
      cnt <= cnt - 4'd1;
  end

endmodule

// File: rtl/match_flow_ctrl.sv
// Match-level sequencer: halves, kickoff/goal/half-time countdowns, pause,
// scores, winner, and the gated tick/reload pulses for the game timer.
module match_flow_ctrl
  import match_pkg::*;
#(
  parameter int KICKOFF_SEC     = 3,
  parameter int GOAL_FREEZE_SEC = 2,
  parameter int HALFTIME_SEC    = 5,
  parameter int MAX_SCORE       = 9
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       one_sec,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       goal_p1,
  input  logic       goal_p2,
  input  logic       timer_zero,
  output logic       timer_tick,
  output logic       timer_reload,
  output logic       ball_reset,
  output logic [2:0] match_state,
  output logic       half,
  output logic [3:0] countdown,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] winner
);

  localparam logic [3:0] KO_VAL = 4'(KICKOFF_SEC);
  localparam logic [3:0] GF_VAL = 4'(GOAL_FREEZE_SEC);
  localparam logic [3:0] HT_VAL = 4'(HALFTIME_SEC);
  localparam logic [3:0] MAX_S  = 4'(MAX_SCORE);

  function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic inc);
    if (inc && s < MAX_S) return s + 4'd1;
    return s;
  endfunction

  match_state_t state;
  logic         cd_tick, cd_done, cd_load;
  logic [3:0]   cd_val, s1_nxt, s2_nxt;
  logic         start_ev, goal_ev, tz_ev, pause_ev, freeze_done;

  assign timer_tick  = one_sec & (state == PLAY);
  assign match_state = state;

  // Event decode shared by the counter load logic and the FSM below.
  always_comb begin
    start_ev    = start_btn & (state == IDLE || state == GAME_OVER);
    goal_ev     = (goal_p1 | goal_p2) & (state == PLAY);
    tz_ev       = timer_zero & (state == PLAY);
    pause_ev    = pause_btn & (state == PLAY || state == PAUSED);
    freeze_done = cd_done & (state == GOAL_FREEZE || state == HALFTIME);
    cd_tick     = one_sec & (state == KICKOFF || state == GOAL_FREEZE || state == HALFTIME);
    s1_nxt      = sat_inc(score_p1, goal_p1);
    s2_nxt      = sat_inc(score_p2, goal_p2);
    cd_load     = 1'b0;
    cd_val      = KO_VAL;
    if (start_ev || freeze_done) begin
      cd_load = 1'b1;
      cd_val  = KO_VAL;
    end else if (tz_ev) begin
      cd_load = ~half;
      cd_val  = HT_VAL;
    end else if (goal_ev) begin
      cd_load = 1'b1;
      cd_val  = GF_VAL;
    end
  end

  sec_countdown u_cd (
    .clk      (clk),
    .resetN   (resetN),
    .load     (cd_load),
    .load_val (cd_val),
    .tick     (cd_tick),
    .cnt      (countdown),
    .done     (cd_done)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      half         <= 1'b0;
      score_p1     <= 4'd0;
      score_p2     <= 4'd0;
      winner       <= WINNER_NONE;
      timer_reload <= 1'b0;
      ball_reset   <= 1'b0;
    end else begin
      timer_reload <= 1'b0;
      ball_reset   <= 1'b0;
      case (state)
        IDLE, GAME_OVER: if (start_ev) begin
          state        <= KICKOFF;
          half         <= 1'b0;
          score_p1     <= 4'd0;
          score_p2     <= 4'd0;
          winner       <= WINNER_NONE;
          timer_reload <= 1'b1;
          ball_reset   <= 1'b1;
        end
        KICKOFF: if (cd_done) state <= PLAY;
        GOAL_FREEZE, HALFTIME: if (cd_done) begin
          state      <= KICKOFF;
          ball_reset <= 1'b1;
        end
        PLAY: begin
          score_p1 <= s1_nxt;
          score_p2 <= s2_nxt;
          // End of a half overrides the goal freeze; the goal still counts.
          if (tz_ev) begin
            if (!half) begin
              state        <= HALFTIME;
              half         <= 1'b1;
              timer_reload <= 1'b1;
            end else begin
              state  <= GAME_OVER;
              winner <= decide_winner(s1_nxt, s2_nxt);
            end
          end else if (goal_ev)
            state <= GOAL_FREEZE;
          else if (pause_ev)
            state <= PAUSED;
        end
        PAUSED: if (pause_ev) state <= PLAY;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_flow_ctrl.sv
// Bench for match_flow_ctrl: directed vector table, corner sequences, and a
// randomized run against a behavioural model of the match rules.
module tb_match_flow_ctrl;
  import match_pkg::*;

  localparam int KO = 3, GF = 2, HT = 5, MX = 9;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       one_sec = 0, start_btn = 0, pause_btn = 0, goal_p1 = 0, goal_p2 = 0, timer_zero = 0;
  logic       timer_tick, timer_reload, ball_reset, half;
  logic [2:0] match_state;
  logic [3:0] countdown, score_p1, score_p2;
  logic [1:0] winner;

  int total = 0;
  int bad = 0;

  match_flow_ctrl dut (
    .clk(clk), .resetN(resetN), .one_sec(one_sec), .start_btn(start_btn),
    .pause_btn(pause_btn), .goal_p1(goal_p1), .goal_p2(goal_p2),
    .timer_zero(timer_zero), .timer_tick(timer_tick), .timer_reload(timer_reload),
    .ball_reset(ball_reset), .match_state(match_state), .half(half),
    .countdown(countdown), .score_p1(score_p1), .score_p2(score_p2), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic os, st, pa, g1, g2, tz;
    logic [2:0] e_st;
    logic [3:0] e_cd, e_s1, e_s2;
    logic e_half, e_tick, e_rel, e_ball;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic os, st, pa, g1, g2, tz,
                              input int es, ecd, es1, es2,
                              input logic eh, etk, erl, ebl);
    vec_t v;
    v.os = os; v.st = st; v.pa = pa; v.g1 = g1; v.g2 = g2; v.tz = tz;
    v.e_st = 3'(es); v.e_cd = 4'(ecd); v.e_s1 = 4'(es1); v.e_s2 = 4'(es2);
    v.e_half = eh; v.e_tick = etk; v.e_rel = erl; v.e_ball = ebl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs; tick_seen is timer_tick before the edge.
  task automatic drive(input logic os, st, pa, g1, g2, tz, output logic tick_seen);
    one_sec = os; start_btn = st; pause_btn = pa; goal_p1 = g1; goal_p2 = g2; timer_zero = tz;
    #1 tick_seen = timer_tick;
    @(posedge clk);
    #1;
    one_sec = 0; start_btn = 0; pause_btn = 0; goal_p1 = 0; goal_p2 = 0; timer_zero = 0;
  endtask

  task automatic secs(input int n);
    logic t;
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, t);
  endtask

  task automatic score_goal(input logic g1, input logic g2);
    logic t;
    drive(0, 0, 0, g1, g2, 0, t);
    secs(GF + KO);
  endtask

  // Behavioural model state
  match_state_t m_st;
  int m_rem, m_s1, m_s2, m_win;
  logic m_half, m_rel, m_ball;

  task automatic model_reset();
    m_st = IDLE; m_rem = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_half = 0; m_rel = 0; m_ball = 0;
  endtask

  task automatic model_step(input logic os, st, pa, g1, g2, tz);
    m_rel = 0; m_ball = 0;
    case (m_st)
      IDLE, GAME_OVER: if (st) begin
        m_st = KICKOFF; m_rem = KO; m_s1 = 0; m_s2 = 0; m_half = 0; m_win = 0;
        m_rel = 1; m_ball = 1;
      end
      KICKOFF, GOAL_FREEZE, HALFTIME: if (os) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          if (m_st != KICKOFF) begin m_rem = KO; m_ball = 1; m_st = KICKOFF; end
          else m_st = PLAY;
        end
      end
      PLAY: begin
        if (g1) m_s1 = (m_s1 + 1 > MX) ? MX : m_s1 + 1;
        if (g2) m_s2 = (m_s2 + 1 > MX) ? MX : m_s2 + 1;
        if (tz && !m_half) begin m_st = HALFTIME; m_rem = HT; m_half = 1; m_rel = 1; end
        else if (tz) begin
          m_st = GAME_OVER;
          m_win = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
        end
        else if (g1 || g2) begin m_st = GOAL_FREEZE; m_rem = GF; end
        else if (pa) m_st = PAUSED;
      end
      PAUSED: if (pa) m_st = PLAY;
      default: ;
    endcase
  endtask

  initial begin
    logic t;
    #23 resetN = 1'b1;
    @(posedge clk); #1;

    chk("rst_state", 8'(match_state), 8'd0);
    chk("rst_cd", 8'(countdown), 8'd0);
    chk("rst_scores", {score_p1, score_p2}, 8'd0);
    chk("rst_winner", 8'(winner), 8'd0);
    chk("rst_half", 8'(half), 8'd0);
    chk("rst_pulses", {6'd0, timer_reload, ball_reset}, 8'd0);

    tbl[0]  = mk(0,1,0,0,0,0, 1,3,0,0, 0,0,1,1);
    tbl[1]  = mk(1,0,0,0,0,0, 1,2,0,0, 0,0,0,0);
    tbl[2]  = mk(1,0,0,0,0,0, 1,1,0,0, 0,0,0,0);
    tbl[3]  = mk(1,0,0,0,0,0, 2,0,0,0, 0,0,0,0);
    tbl[4]  = mk(0,0,0,0,1,0, 4,2,0,1, 0,0,0,0);
    tbl[5]  = mk(1,0,0,0,0,0, 4,1,0,1, 0,0,0,0);
    tbl[6]  = mk(1,0,0,0,0,0, 1,3,0,1, 0,0,0,1);
    tbl[7]  = mk(1,0,0,0,0,0, 1,2,0,1, 0,0,0,0);
    tbl[8]  = mk(1,0,0,0,0,0, 1,1,0,1, 0,0,0,0);
    tbl[9]  = mk(1,0,0,0,0,0, 2,0,0,1, 0,0,0,0);
    tbl[10] = mk(0,0,1,0,0,0, 3,0,0,1, 0,0,0,0);
    tbl[11] = mk(1,0,0,0,0,0, 3,0,0,1, 0,0,0,0);
    tbl[12] = mk(0,0,0,1,0,0, 3,0,0,1, 0,0,0,0);
    tbl[13] = mk(0,0,0,0,0,1, 3,0,0,1, 0,0,0,0);
    tbl[14] = mk(0,0,1,0,0,0, 2,0,0,1, 0,0,0,0);
    tbl[15] = mk(1,0,0,0,0,0, 2,0,0,1, 0,1,0,0);
    tbl[16] = mk(0,0,0,0,0,1, 5,5,0,1, 1,0,1,0);
    tbl[17] = mk(1,0,0,0,0,0, 5,4,0,1, 1,0,0,0);
    tbl[18] = mk(1,0,0,0,0,0, 5,3,0,1, 1,0,0,0);
    tbl[19] = mk(1,0,0,0,0,0, 5,2,0,1, 1,0,0,0);
    tbl[20] = mk(1,0,0,0,0,0, 5,1,0,1, 1,0,0,0);
    tbl[21] = mk(1,0,0,0,0,0, 1,3,0,1, 1,0,0,1);
    tbl[22] = mk(1,0,0,0,0,0, 1,2,0,1, 1,0,0,0);
    tbl[23] = mk(1,0,0,0,0,0, 1,1,0,1, 1,0,0,0);
    tbl[24] = mk(1,0,0,0,0,0, 2,0,0,1, 1,0,0,0);

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].os, tbl[i].st, tbl[i].pa, tbl[i].g1, tbl[i].g2, tbl[i].tz, t);
      chk($sformatf("v%0d_tick", i), 8'(t), 8'(tbl[i].e_tick));
      chk($sformatf("v%0d_state", i), 8'(match_state), 8'(tbl[i].e_st));
      chk($sformatf("v%0d_cd", i), 8'(countdown), 8'(tbl[i].e_cd));
      chk($sformatf("v%0d_scores", i), {score_p1, score_p2}, {tbl[i].e_s1, tbl[i].e_s2});
      chk($sformatf("v%0d_half", i), 8'(half), 8'(tbl[i].e_half));
      chk($sformatf("v%0d_pulses", i), {6'd0, timer_reload, ball_reset},
          {6'd0, tbl[i].e_rel, tbl[i].e_ball});
    end

    // Second half, 2-2, then goal and full time together.
    score_goal(1, 0);
    score_goal(1, 0);
    score_goal(0, 1);
    chk("sh_scores", {score_p1, score_p2}, 8'h22);
    chk("sh_state", 8'(match_state), 8'(PLAY));
    drive(0, 0, 0, 1, 0, 1, t);
    chk("ft_score_p1", 8'(score_p1), 8'd3);
    chk("ft_state", 8'(match_state), 8'(GAME_OVER));
    chk("ft_winner", 8'(winner), 8'(WINNER_P1));
    drive(0, 0, 1, 1, 0, 0, t);
    chk("go_ignores", {1'b0, match_state, score_p1}, {1'b0, 3'(GAME_OVER), 4'd3});

    // New match, reach second half, both score on the final whistle.
    drive(0, 1, 0, 0, 0, 0, t);
    chk("restart_clear", {score_p1, score_p2}, 8'h00);
    chk("restart_winner", {5'd0, half, winner}, 8'd0);
    secs(KO);
    drive(0, 0, 0, 0, 0, 1, t);
    secs(HT + KO);
    chk("draw_pre_state", 8'(match_state), 8'(PLAY));
    drive(0, 0, 0, 1, 1, 1, t);
    chk("draw_scores", {score_p1, score_p2}, 8'h11);
    chk("draw_winner", {match_state, 3'd0, winner}, {3'(GAME_OVER), 3'd0, WINNER_DRAW});

    // Saturation, then asynchronous reset during kickoff.
    drive(0, 1, 0, 0, 0, 0, t);
    secs(KO);
    for (int i = 0; i < 10; i++) score_goal(1, 0);
    chk("sat_score_p1", 8'(score_p1), 8'(MX));
    drive(0, 0, 0, 1, 0, 0, t);
    secs(GF + 1);
    chk("pre_rst_state", {match_state, countdown}, {3'(KICKOFF), 4'd2});
    #2 resetN = 1'b0;
    #1;
    chk("arst_state", {match_state, countdown}, 7'd0);
    chk("arst_scores", {score_p1, score_p2}, 8'd0);
    chk("arst_misc", {4'd0, half, winner, ball_reset | timer_reload}, 8'd0);
    resetN = 1'b1;
    @(posedge clk); #1;

    // Randomized run against the model.
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      logic os, st, pa, g1, g2, tz, etick;
      os = ($urandom_range(0, 99) < 30);
      st = ($urandom_range(0, 99) < 4);
      pa = ($urandom_range(0, 99) < 5);
      g1 = ($urandom_range(0, 99) < 8);
      g2 = ($urandom_range(0, 99) < 8);
      tz = ($urandom_range(0, 99) < 3);
      etick = os && (m_st == PLAY);
      drive(os, st, pa, g1, g2, tz, t);
      model_step(os, st, pa, g1, g2, tz);
      chk($sformatf("r%0d_tick", c), 8'(t), 8'(etick));
      chk($sformatf("r%0d_state", c), 8'(match_state), 8'(m_st));
      chk($sformatf("r%0d_cd", c), 8'(countdown),
          (m_st == KICKOFF || m_st == GOAL_FREEZE || m_st == HALFTIME) ? 8'(m_rem) : 8'd0);
      chk($sformatf("r%0d_scores", c), {score_p1, score_p2}, {4'(m_s1), 4'(m_s2)});
      chk($sformatf("r%0d_hw", c), {5'd0, half, winner}, {5'd0, m_half, 2'(m_win)});
      chk($sformatf("r%0d_pulses", c), {6'd0, timer_reload, ball_reset}, {6'd0, m_rel, m_ball});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
